// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-ported memory between
// an instruction-fetch port (0) and a load/store port (1).
module mem_port_arbiter #(
  parameter int MEM_LAT = 1,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [15:0]       conflict_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } state_t;

  state_t     state;
  logic       last;
  logic       owner;
  logic       win;
  logic       both;
  logic [2:0] lat_cnt;

  // On a tie the port that did not win last time goes first.
  always_comb begin
    both = m0_req & m1_req;
    win  = both ? ~last : m1_req;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      last         <= 1'b1;
      owner        <= 1'b0;
      lat_cnt      <= '0;
      m0_gnt       <= 1'b0;
      m1_gnt       <= 1'b0;
      m0_rvalid    <= 1'b0;
      m1_rvalid    <= 1'b0;
      m0_rdata     <= '0;
      m1_rdata     <= '0;
      mem_en       <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      conflict_cnt <= '0;
    end else begin
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (m0_req || m1_req) begin
            state     <= ISSUE;
            owner     <= win;
            last      <= win;
            m0_gnt    <= ~win;
            m1_gnt    <= win;
            mem_en    <= 1'b1;
            mem_we    <= win ? m1_we : m0_we;
            mem_addr  <= win ? m1_addr : m0_addr;
            mem_wdata <= win ? m1_wdata : m0_wdata;
            if (both && conflict_cnt != 16'hFFFF)
              conflict_cnt <= conflict_cnt + 16'd1;
          end
        end
        ISSUE: begin
          m0_gnt <= 1'b0;
          m1_gnt <= 1'b0;
          mem_en <= 1'b0;
          mem_we <= 1'b0;
          if (mem_we) begin
            state <= IDLE;
          end else begin
            lat_cnt <= 3'(MEM_LAT);
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (lat_cnt == 3'd1) begin
            state <= IDLE;
            if (owner) begin
              m1_rdata  <= mem_rdata;
              m1_rvalid <= 1'b1;
            end else begin
              m0_rdata  <= mem_rdata;
              m0_rvalid <= 1'b1;
            end
          end else begin
            lat_cnt <= lat_cnt - 3'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: timeline reference model with
// directed and random requester traffic.
module tb_mem_port_arbiter;
  localparam int L  = 1;
  localparam int L3 = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [1:0]  req, we;
  logic [31:0] addr [2];
  logic [31:0] wdata[2];
  logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [15:0] conflict_cnt;

  logic        req3;
  logic [31:0] addr3;
  logic        g3_0, g3_1, rv3_0, rv3_1, en3, we3;
  logic [31:0] rd3_0, rd3_1, maddr3, mwdata3, mrdata3;
  logic [15:0] conf3;

  mem_port_arbiter #(.MEM_LAT(L)) dut (
    .clk(clk), .reset(reset),
    .m0_req(req[0]), .m0_we(we[0]),
    .m0_addr(addr[0]), .m0_wdata(wdata[0]),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(req[1]), .m1_we(we[1]),
    .m1_addr(addr[1]), .m1_wdata(wdata[1]),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .conflict_cnt(conflict_cnt)
  );

  mem_port_arbiter #(.MEM_LAT(L3)) dut3 (
    .clk(clk), .reset(reset),
    .m0_req(req3), .m0_we(1'b0),
    .m0_addr(addr3), .m0_wdata(32'h0),
    .m0_gnt(g3_0), .m0_rvalid(rv3_0), .m0_rdata(rd3_0),
    .m1_req(1'b0), .m1_we(1'b0),
    .m1_addr(32'h0), .m1_wdata(32'h0),
    .m1_gnt(g3_1), .m1_rvalid(rv3_1), .m1_rdata(rd3_1),
    .mem_en(en3), .mem_we(we3), .mem_addr(maddr3),
    .mem_wdata(mwdata3), .mem_rdata(mrdata3),
    .conflict_cnt(conf3)
  );

  // Memory device: data only valid in the exact latency cycle.
  bit [31:0]  init_mem[256];
  bit [31:0]  dev_mem [256];
  bit [255:0] dev_wr;
  int         rd_cnt = -1;
  logic [7:0] rd_idx = '0;
  int         rd3 = -1;

  always @(posedge clk) begin
    if (mem_en && mem_we) begin
      dev_mem[mem_addr[9:2]] <= mem_wdata;
      dev_wr[mem_addr[9:2]]  <= 1'b1;
    end
    if (mem_en && !mem_we) begin
      rd_cnt <= L - 1;
      rd_idx <= mem_addr[9:2];
    end else if (rd_cnt >= 0) begin
      rd_cnt <= rd_cnt - 1;
    end
    if (en3 && !we3) rd3 <= L3 - 1;
    else if (rd3 >= 0) rd3 <= rd3 - 1;
  end

  assign mem_rdata = (rd_cnt == 0) ?
    (dev_wr[rd_idx] ? dev_mem[rd_idx] : init_mem[rd_idx]) :
    32'hBAD0_0001;
  assign mrdata3 = (rd3 == 0) ? (maddr3 ^ 32'h5A5A_0000) :
    32'hBAD0_0003;

  // Reference model: transaction timeline in cycle numbers.
  int          n_assert = 0, n_fail = 0;
  int          cyc = 0, gnt_cyc = -1, rv_cyc = -1, free_at = 0;
  bit          own, own_we, last_p = 1'b1, mw;
  logic [31:0] g_addr, g_wdata, g_rd;
  logic [31:0] e_rdata[2];
  logic [31:0] e_maddr, e_mwdata;
  int          e_conf = 0;
  bit [31:0]   ref_mem[256];
  bit [255:0]  ref_wr;
  bit          rnd = 1'b0, cont = 1'b0;

  task automatic model_reset();
    gnt_cyc = -1; rv_cyc = -1; free_at = 0; last_p = 1'b1;
    e_rdata[0] = '0; e_rdata[1] = '0;
    e_maddr = '0; e_mwdata = '0; e_conf = 0;
  endtask

  task automatic model_edge();
    logic [7:0] idx;
    if (cyc >= free_at && req != 2'b00) begin
      mw = (req == 2'b11) ? ~last_p : req[1];
      if (req == 2'b11 && e_conf < 65535) e_conf++;
      last_p  = mw;
      own     = mw;
      own_we  = we[mw];
      g_addr  = addr[mw];
      g_wdata = wdata[mw];
      idx     = g_addr[9:2];
      gnt_cyc = cyc + 1;
      if (own_we) begin
        ref_mem[idx] = g_wdata;
        ref_wr[idx]  = 1'b1;
        rv_cyc  = -1;
        free_at = cyc + 2;
      end else begin
        g_rd    = ref_wr[idx] ? ref_mem[idx] : init_mem[idx];
        rv_cyc  = cyc + 2 + L;
        free_at = cyc + 2 + L;
      end
    end
    cyc++;
    if (cyc == gnt_cyc) begin
      e_maddr  = g_addr;
      e_mwdata = g_wdata;
    end
    if (cyc == rv_cyc) e_rdata[own] = g_rd;
  endtask

  task automatic chk1(input string tag, input logic obs,
                      input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s cyc %0d: got %b want %b", tag, cyc, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s cyc %0d: got %h want %h", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_all();
    chk1("m0_gnt", m0_gnt, cyc == gnt_cyc && !own);
    chk1("m1_gnt", m1_gnt, cyc == gnt_cyc && own);
    chk1("mem_en", mem_en, cyc == gnt_cyc);
    chk1("mem_we", mem_we, cyc == gnt_cyc && own_we);
    chk1("m0_rvalid", m0_rvalid, cyc == rv_cyc && !own);
    chk1("m1_rvalid", m1_rvalid, cyc == rv_cyc && own);
    chk32("m0_rdata", m0_rdata, e_rdata[0]);
    chk32("m1_rdata", m1_rdata, e_rdata[1]);
    chk32("mem_addr", mem_addr, e_maddr);
    chk32("mem_wdata", mem_wdata, e_mwdata);
    chk32("conflict_cnt", 32'(conflict_cnt), 32'(e_conf));
  endtask

  task automatic rand_req(input int p, input logic w);
    req[p]   = 1'b1;
    we[p]    = w;
    addr[p]  = $urandom() & 32'hFFFF_FFFC;
    wdata[p] = $urandom();
  endtask

  task automatic step();
    @(posedge clk);
    if (reset) model_edge();
    @(negedge clk);
    check_all();
    for (int p = 0; p < 2; p++) begin
      if (req[p] && cyc == gnt_cyc && own == 1'(p)) begin
        if (cont) rand_req(p, 1'b0);
        else req[p] = 1'b0;
      end else if (rnd && !req[p] && $urandom_range(0, 2) == 0) begin
        rand_req(p, 1'($urandom_range(0, 1)));
      end
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 60; k++) begin
      if (req == 2'b00 && cyc >= free_at) break;
      step();
    end
    chk1("drain_idle", req == 2'b00 && cyc >= free_at, 1'b1);
  endtask

  task automatic do_reset();
    #2 reset = 1'b0;
    req = 2'b00;
    model_reset();
    #1 check_all();
    step();
    step();
    reset = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    int n0;
    logic [1:0] pat[$];
    req = '0; we = '0; req3 = 1'b0; addr3 = '0;
    for (int i = 0; i < 2; i++) begin
      addr[i] = '0; wdata[i] = '0;
    end
    for (int i = 0; i < 256; i++) init_mem[i] = $urandom();
    init_mem[4] = 32'hDEAD_BEEF;
    reset = 1'b1;
    #1 reset = 1'b0;
    model_reset();
    #1 check_all();
    step();
    step();
    reset = 1'b1;

    // Single read of 0x10 by port 0.
    req[0] = 1'b1; we[0] = 1'b0; addr[0] = 32'h10;
    step();
    chk1("t1_gnt", m0_gnt, 1'b1);
    chk32("t1_addr", mem_addr, 32'h10);
    step();
    step();
    chk1("t1_rvalid", m0_rvalid, 1'b1);
    chk32("t1_rdata", m0_rdata, 32'hDEAD_BEEF);
    chk32("t1_m1_rdata", m1_rdata, 32'h0);
    drain();

    // First tie after reset goes to port 0, then port 1.
    do_reset();
    rand_req(0, 1'b0);
    rand_req(1, 1'b0);
    step();
    chk1("t2_first_m0", m0_gnt, 1'b1);
    step();
    step();
    step();
    chk1("t2_second_m1", m1_gnt, 1'b1);
    chk32("t2_conflict", 32'(conflict_cnt), 32'd1);
    drain();

    // Both ports requesting back to back must alternate.
    cont = 1'b1;
    rand_req(0, 1'b0);
    rand_req(1, 1'b0);
    n = 0;
    for (int k = 0; k < 80 && n < 6; k++) begin
      step();
      if (cyc == gnt_cyc) begin
        pat.push_back({m1_gnt, m0_gnt});
        n++;
        if (n == 6) req[own] = 1'b0;
      end
    end
    cont = 1'b0;
    chk32("t3_count", 32'(pat.size()), 32'd6);
    for (int i = 0; i < pat.size(); i++)
      chk32("t3_order", 32'(pat[i]), (i % 2 == 0) ? 32'd1 : 32'd2);
    drain();

    // Port 1 write then read back of 0x20.
    req[1] = 1'b1; we[1] = 1'b1;
    addr[1] = 32'h20; wdata[1] = 32'h1234_5678;
    step();
    chk1("t4_we", mem_we, 1'b1);
    step();
    chk1("t4_we_drop", mem_we, 1'b0);
    req[1] = 1'b1; we[1] = 1'b0; addr[1] = 32'h20;
    step();
    step();
    step();
    chk1("t4_rvalid", m1_rvalid, 1'b1);
    chk32("t4_rdata", m1_rdata, 32'h1234_5678);
    drain();

    // Random traffic from both requesters.
    rnd = 1'b1;
    for (int k = 0; k < 400; k++) step();
    rnd = 1'b0;
    drain();

    // Reset while a read is waiting on memory.
    rand_req(0, 1'b0);
    step();
    step();
    do_reset();
    chk1("rst_rvalid", m0_rvalid, 1'b0);
    chk32("rst_rdata", m0_rdata, 32'h0);
    for (int k = 0; k < 4; k++) step();
    rand_req(0, 1'b0);
    rand_req(1, 1'b0);
    step();
    chk1("rst_tie_m0", m0_gnt, 1'b1);
    chk1("rst_tie_m1", m1_gnt, 1'b0);
    drain();

    // Latency 3: rvalid at N+4, next grant at N+5.
    req3 = 1'b1;
    addr3 = $urandom() & 32'hFFFF_FFFC;
    n0 = cyc + 1;
    for (int k = 0; k < 6; k++) begin
      step();
      chk1("lat_gnt", g3_0, cyc == n0 || cyc == n0 + 5);
      chk1("lat_en", en3, cyc == n0 || cyc == n0 + 5);
      chk1("lat_m1_gnt", g3_1, 1'b0);
      chk1("lat_rvalid", rv3_0, cyc == n0 + 4);
      if (cyc == n0 + 4)
        chk32("lat_rdata", rd3_0, addr3 ^ 32'h5A5A_0000);
      if (cyc == n0 + 5) req3 = 1'b0;
    end
    for (int k = 0; k < 6; k++) step();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end
endmodule
